// File: rtl/spi2wb_pkg.sv
// Shared types and constants for the SPI-to-Wishbone bridge.
package spi2wb_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 2;

  localparam int RW_BIT   = 7;
  localparam int ADDR_LSB = 0;

  localparam logic [7:0] TURN_BYTE = 8'h00;
  localparam logic [7:0] FILL_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_WR_DATA,
    ST_WB_WR,
    ST_TURN,
    ST_RD_DATA,
    ST_DRAIN
  } state_e;

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave front end: input synchronisers, sck edge detect,
// bit counter and RX/TX shift registers, all in the clk_i domain.
module spi_slave_shifter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         sck_i,
  input  logic         ss_n_i,
  input  logic         mosi_i,
  input  logic [W-1:0] tx_byte_i,
  output logic         tx_load_o,
  output logic         frame_start_o,
  output logic         frame_end_o,
  output logic         frame_active_o,
  output logic         mid_byte_o,
  output logic         byte_done_o,
  output logic [W-1:0] rx_byte_o,
  output logic         miso_o
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  logic [1:0]    sck_s_q, ss_s_q, mosi_s_q;
  logic          sck_prev_q, boot_q, armed_q, active_q, byte_done_q;
  logic [CW-1:0] bit_cnt_q;
  logic [W-1:0]  rx_sr_q, tx_sr_q, rx_byte_q;

  logic sck_sync, ss_sync, mosi_sync;
  logic sck_rise, sck_fall, frame_start, frame_end, last_bit, tx_load;

  assign sck_sync  = sck_s_q[1];
  assign ss_sync   = ss_s_q[1];
  assign mosi_sync = mosi_s_q[1];

  assign sck_rise    = active_q & ~ss_sync &  sck_sync & ~sck_prev_q;
  assign sck_fall    = active_q & ~ss_sync & ~sck_sync &  sck_prev_q;
  // armed_q blocks a stale low ss_n at reset release from opening a frame
  assign frame_start = armed_q & ~active_q & ~ss_sync;
  assign frame_end   = active_q & ss_sync;
  assign last_bit    = (bit_cnt_q == CW'(W - 1));
  assign tx_load     = frame_start | (sck_fall & (bit_cnt_q == '0));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sck_s_q     <= 2'b00;
      ss_s_q      <= 2'b11;
      mosi_s_q    <= 2'b00;
      sck_prev_q  <= 1'b0;
      boot_q      <= 1'b0;
      armed_q     <= 1'b0;
      active_q    <= 1'b0;
      byte_done_q <= 1'b0;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      rx_byte_q   <= '0;
    end else begin
      sck_s_q     <= {sck_s_q[0], sck_i};
      ss_s_q      <= {ss_s_q[0], ss_n_i};
      mosi_s_q    <= {mosi_s_q[0], mosi_i};
      sck_prev_q  <= sck_sync;
      boot_q      <= 1'b1;
      byte_done_q <= 1'b0;
      if (boot_q && ss_s_q == 2'b11) armed_q <= 1'b1;

      if (frame_start) begin
        active_q  <= 1'b1;
        bit_cnt_q <= '0;
        rx_sr_q   <= '0;
      end else if (frame_end) begin
        active_q  <= 1'b0;
        bit_cnt_q <= '0;
      end

      if (sck_rise) begin
        rx_sr_q   <= {rx_sr_q[W-2:0], mosi_sync};
        bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 1'b1;
        if (last_bit) begin
          byte_done_q <= 1'b1;
          rx_byte_q   <= {rx_sr_q[W-2:0], mosi_sync};
        end
      end

      if (tx_load)       tx_sr_q <= tx_byte_i;
      else if (sck_fall) tx_sr_q <= {tx_sr_q[W-2:0], 1'b0};
    end
  end

  assign tx_load_o      = tx_load;
  assign frame_start_o  = frame_start;
  assign frame_end_o    = frame_end;
  assign frame_active_o = active_q;
  assign mid_byte_o     = (bit_cnt_q != '0);
  assign byte_done_o    = byte_done_q;
  assign rx_byte_o      = rx_byte_q;
  assign miso_o         = tx_sr_q[W-1] & active_q;

endmodule

// File: rtl/spi2wb_bridge.sv
// SPI slave to Wishbone classic master bridge: one register access per frame.
//   state      | meaning
//   IDLE       | no frame open
//   CMD        | receiving command byte
//   WR_DATA    | receiving write data byte
//   WB_WR      | WB write in flight
//   TURN       | turnaround byte, WB read in flight
//   RD_DATA    | shifting read data out
//   DRAIN      | bytes past the frame's end, ignored
module spi2wb_bridge
  import spi2wb_pkg::*;
#(
  parameter int WB_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int WB_ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int WB_TIMEOUT    = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sck_i,
  input  logic                     ss_n_i,
  input  logic                     mosi_i,
  output logic                     miso_o,
  output logic                     miso_oe_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_adr_o,
  output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
  input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  input  logic                     wb_ack_i,
  output logic                     frame_err_o
);

  localparam int TW = $clog2(WB_TIMEOUT + 1);

  state_e state_q, state_d;

  logic                     tx_load, frame_start, frame_end, frame_active;
  logic                     mid_byte, byte_done;
  logic [WB_DATA_WIDTH-1:0] rx_byte, tx_byte;

  logic                     cyc_q, we_q, rd_valid_q, rd_err_q, frame_err_q;
  logic [WB_ADDR_WIDTH-1:0] adr_q, cmd_adr_q;
  logic [WB_DATA_WIDTH-1:0] dat_q, rd_data_q;
  logic [TW-1:0]            tmo_q;

  logic                     wb_start, start_we;
  logic [WB_ADDR_WIDTH-1:0] start_adr;
  logic [WB_DATA_WIDTH-1:0] start_dat;
  logic                     timeout_hit, rd_miss;

  spi_slave_shifter #(.W(WB_DATA_WIDTH)) u_shifter (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .sck_i          (sck_i),
    .ss_n_i         (ss_n_i),
    .mosi_i         (mosi_i),
    .tx_byte_i      (tx_byte),
    .tx_load_o      (tx_load),
    .frame_start_o  (frame_start),
    .frame_end_o    (frame_end),
    .frame_active_o (frame_active),
    .mid_byte_o     (mid_byte),
    .byte_done_o    (byte_done),
    .rx_byte_o      (rx_byte),
    .miso_o         (miso_o)
  );

  assign tx_byte = (state_q == ST_RD_DATA)
                 ? (rd_valid_q ? rd_data_q : WB_DATA_WIDTH'(FILL_BYTE))
                 : WB_DATA_WIDTH'(TURN_BYTE);

  assign timeout_hit = cyc_q & ~wb_ack_i & (tmo_q == '0);
  // a read that timed out has already flagged its error once
  assign rd_miss = tx_load & (state_q == ST_RD_DATA) & ~rd_valid_q & ~rd_err_q;

  always_comb begin
    state_d   = state_q;
    wb_start  = 1'b0;
    start_we  = 1'b0;
    start_adr = adr_q;
    start_dat = dat_q;
    if (frame_end) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (frame_start) state_d = ST_CMD;
        ST_CMD: begin
          if (byte_done) begin
            if (rx_byte[RW_BIT]) begin
              wb_start  = 1'b1;
              start_adr = rx_byte[ADDR_LSB +: WB_ADDR_WIDTH];
              state_d   = ST_TURN;
            end else begin
              state_d   = ST_WR_DATA;
            end
          end
        end
        ST_WR_DATA: begin
          if (byte_done) begin
            wb_start  = 1'b1;
            start_we  = 1'b1;
            start_adr = cmd_adr_q;
            start_dat = rx_byte;
            state_d   = ST_WB_WR;
          end
        end
        ST_WB_WR:   if (byte_done || !cyc_q) state_d = ST_DRAIN;
        ST_TURN:    if (byte_done) state_d = ST_RD_DATA;
        ST_RD_DATA: if (byte_done) state_d = ST_DRAIN;
        ST_DRAIN:   state_d = ST_DRAIN;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      cmd_adr_q   <= '0;
      tmo_q       <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_err_q    <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_err_q <= timeout_hit | (frame_end & mid_byte) | rd_miss;
      if (state_q == ST_CMD && byte_done)
        cmd_adr_q <= rx_byte[ADDR_LSB +: WB_ADDR_WIDTH];
      if (frame_start) begin
        rd_valid_q <= 1'b0;
        rd_err_q   <= 1'b0;
      end

      if (wb_start && !cyc_q) begin
        cyc_q <= 1'b1;
        we_q  <= start_we;
        adr_q <= start_adr;
        dat_q <= start_dat;
        tmo_q <= TW'(WB_TIMEOUT - 1);
      end else if (cyc_q) begin
        if (wb_ack_i) begin
          cyc_q <= 1'b0;
          tmo_q <= '0;
          if (!we_q) begin
            rd_data_q  <= wb_dat_i;
            rd_valid_q <= 1'b1;
          end
        end else if (tmo_q == '0) begin
          cyc_q <= 1'b0;
          if (!we_q) rd_err_q <= 1'b1;
        end else begin
          tmo_q <= tmo_q - 1'b1;
        end
      end
    end
  end

  assign miso_oe_o   = frame_active;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_spi2wb_bridge.sv
// Directed and randomized frames against a transaction-level model of the bridge.
module tb_spi2wb_bridge;

  localparam int HALF    = 80;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0, rst = 1'b1;
  logic       sck = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] dat_i = 8'h00;
  logic       miso_o, miso_oe_o, wb_we_o, wb_cyc_o, wb_stb_o, frame_err_o;
  logic [1:0] wb_adr_o;
  logic [7:0] wb_dat_o;

  spi2wb_bridge #(.WB_DATA_WIDTH(8), .WB_ADDR_WIDTH(2), .WB_TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .rst_i(rst), .sck_i(sck), .ss_n_i(ss_n), .mosi_i(mosi),
    .miso_o(miso_o), .miso_oe_o(miso_oe_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(dat_i), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(ack),
    .frame_err_o(frame_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wishbone slave: records each cycle, acks after ack_dly cycles (large = never)
  int         ack_dly = 2;
  logic [7:0] rd_val = 8'h00;
  int         q_adr[$], q_dat[$], q_we[$], q_len[$];
  int         cur_len = 0, err_pulses = 0;
  bit         stable_bad = 1'b0;
  logic [1:0] s_adr;
  logic [7:0] s_dat;
  logic       s_we;

  initial begin
    forever begin
      @(negedge clk);
      if (frame_err_o) err_pulses++;
      if (wb_cyc_o) begin
        if (cur_len == 0) begin
          s_adr = wb_adr_o; s_dat = wb_dat_o; s_we = wb_we_o;
        end
        if ({wb_adr_o, wb_dat_o, wb_we_o, wb_stb_o} !== {s_adr, s_dat, s_we, 1'b1})
          stable_bad = 1'b1;
        cur_len++;
        if (cur_len > ack_dly) begin
          ack = 1'b1;
          dat_i = rd_val;
        end
      end else begin
        if (cur_len > 0) begin
          q_adr.push_back(int'(s_adr)); q_dat.push_back(int'(s_dat));
          q_we.push_back(int'(s_we));   q_len.push_back(cur_len);
          cur_len = 0;
        end
        ack = 1'b0;
      end
    end
  end

  logic [7:0] ftx[8];
  logic [7:0] frx[8];

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      #HALF;
      sck = 1'b1;
      rx[i] = miso_o;
      #HALF;
      sck = 1'b0;
    end
  endtask

  task automatic clear_obs();
    q_adr.delete(); q_dat.delete(); q_we.delete(); q_len.delete();
    err_pulses = 0;
    stable_bad = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    #(HALF * 2);
    while (wb_cyc_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wb_cycle_ends", int'(wb_cyc_o), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic run_frame(input int nb, input int partial_bits);
    logic [7:0] r;
    clear_obs();
    @(negedge clk);
    ss_n = 1'b0;
    #HALF;
    for (int b = 0; b < nb; b++) begin
      spi_bits(ftx[b], 8, r);
      frx[b] = r;
    end
    if (partial_bits > 0) spi_bits(ftx[nb], partial_bits, r);
    #HALF;
    ss_n = 1'b1;
    wait_idle();
  endtask

  // Reference: one WB access per complete frame; reads answer in byte 3
  task automatic expect_frame(input string tag, input int nb);
    bit         is_rd, timed_out;
    int         adr, exp_len;
    logic [7:0] exp_miso;
    is_rd     = ftx[0][7];
    adr       = int'(ftx[0][1:0]);
    timed_out = (ack_dly >= TIMEOUT);
    exp_len   = timed_out ? TIMEOUT : ack_dly + 1;
    chk({tag, ".txn_count"}, q_adr.size(), 1);
    if (q_adr.size() > 0) begin
      chk({tag, ".adr"}, q_adr[0], adr);
      chk({tag, ".we"},  q_we[0], is_rd ? 0 : 1);
      chk({tag, ".len"}, q_len[0], exp_len);
      if (!is_rd) chk({tag, ".dat"}, q_dat[0], int'(ftx[1]));
    end
    chk({tag, ".stable"}, int'(stable_bad), 0);
    chk({tag, ".errs"}, err_pulses, timed_out ? 1 : 0);
    for (int b = 0; b < nb; b++) begin
      exp_miso = 8'h00;
      if (is_rd && b == 2) exp_miso = timed_out ? 8'hFF : rd_val;
      chk($sformatf("%s.miso%0d", tag, b), int'(frx[b]), int'(exp_miso));
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    int         nb;

    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({miso_o, miso_oe_o, wb_adr_o, wb_dat_o, wb_we_o,
                               wb_cyc_o, wb_stb_o, frame_err_o}), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    ftx[0] = 8'h02; ftx[1] = 8'h5A; ack_dly = 2;
    run_frame(2, 0);
    expect_frame("write_5a", 2);

    ftx[0] = 8'h81; ftx[1] = 8'h00; ftx[2] = 8'h00; rd_val = 8'hC3; ack_dly = 1;
    run_frame(3, 0);
    expect_frame("read_c3", 3);

    ftx[0] = 8'h81; rd_val = 8'h77; ack_dly = 20;
    run_frame(3, 0);
    expect_frame("read_timeout", 3);

    ftx[0] = 8'h83; rd_val = 8'h96; ack_dly = TIMEOUT - 1;
    run_frame(3, 0);
    expect_frame("read_ack_last_clk", 3);

    ftx[0] = 8'h01; ftx[1] = 8'h3C; ack_dly = TIMEOUT;
    run_frame(2, 0);
    expect_frame("write_timeout", 2);

    ftx[0] = 8'h02; ftx[1] = 8'hE7; ack_dly = 2;
    run_frame(1, 5);
    chk("partial.txn_count", q_adr.size(), 0);
    chk("partial.errs", err_pulses, 1);
    ftx[0] = 8'h03; ftx[1] = 8'h11;
    run_frame(2, 0);
    expect_frame("write_after_partial", 2);

    ftx[0] = 8'h00; ftx[1] = 8'hAA; ftx[2] = 8'h55; ftx[3] = 8'hFF; ack_dly = 0;
    run_frame(4, 0);
    expect_frame("write_drain", 4);

    // reset mid-command with ss_n still low across the release
    @(negedge clk);
    ss_n = 1'b0;
    #HALF;
    spi_bits(8'h80, 4, r);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midframe_reset_outputs", int'({miso_o, miso_oe_o, wb_adr_o, wb_dat_o,
                                        wb_we_o, wb_cyc_o, wb_stb_o, frame_err_o}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("no_frame_on_stale_ss", int'(miso_oe_o), 0);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    ftx[0] = 8'h80; ftx[1] = 8'h00; ftx[2] = 8'h00; rd_val = 8'h3C; ack_dly = 1;
    run_frame(3, 0);
    expect_frame("read_after_reset", 3);

    for (int k = 0; k < 14; k++) begin
      ftx[0] = 8'($urandom);
      for (int b = 1; b < 8; b++) ftx[b] = 8'($urandom);
      rd_val  = 8'($urandom);
      ack_dly = int'($urandom_range(0, 7));
      if (ack_dly == 7) ack_dly = 40;
      nb = (ftx[0][7] ? 3 : 2) + int'($urandom_range(0, 2));
      run_frame(nb, 0);
      expect_frame($sformatf("rand%0d", k), nb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
